// File: rtl/ccff_loader_pkg.sv
// Shared state encoding and serial CRC-8 helpers for the configuration-chain loader.
// The readback path (CCFF_LOADER_READBACK_EN) is the only user of the CRC items.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [7:0] CRC_POLY = 8'h07;
   localparam logic [7:0] CRC_INIT = 8'h00;

   // One bit of an MSB-first CRC-8: feedback is the outgoing top bit XOR the new data bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
// Only built when CCFF_LOADER_READBACK_EN is defined; the default build has no CRC logic.
`ifdef CCFF_LOADER_READBACK_EN
module ccff_crc8
   import ccff_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       bit_en,
   input  logic       data_bit,
   output logic [7:0] crc
);

   // CRC register: clear wins over accumulation so a new load always starts from init
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if (clear) begin
         crc <= CRC_INIT;
      end else if (bit_en) begin
         crc <= crc8_step(crc, data_bit);
      end else begin
         crc <= crc;
      end
   end

endmodule
`endif

// File: rtl/ccff_loader.sv
// Streams bitstream words MSB-first into a configuration flip-flop chain of CHAIN_LEN bits.
// Define CCFF_LOADER_READBACK_EN to add a recirculating VERIFY pass checked by CRC-8.
module ccff_loader
   import ccff_loader_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CHAIN_LEN = 36
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int BL_W  = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [BL_W-1:0]  BL_ZERO  = {BL_W{1'b0}};
   localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
   localparam logic [BL_W-1:0]  BL_FULL  = BL_W'(DATA_W);

   state_t            state_r;
   logic [DATA_W-1:0] sreg_r;
   logic [BL_W-1:0]   bits_left_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              done_r;

   logic shift_en_s;
   logic head_s;
   logic ready_s;
   logic last_s;
   logic start_ok_s;

   assign start_ok_s = (state_r == ST_IDLE) && start;

   // Output and handshake decode from registered state only (head follows tail while verifying)
   always_comb begin
      shift_en_s = 1'b0;
      head_s     = 1'b0;
      ready_s    = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         ST_LOAD: begin
            shift_en_s = (bits_left_r != BL_ZERO) && (cnt_r < CNT_MAX);
            if (shift_en_s) begin
               head_s = sreg_r[DATA_W-1];
            end else begin
               head_s = 1'b0;
            end
            last_s  = shift_en_s && (cnt_r == CNT_LAST);
            // the last-shift guard stops a word being taken once the chain is full
            ready_s = (bits_left_r == BL_ZERO) ||
                      ((bits_left_r == BL_ONE) && shift_en_s && !last_s);
         end
`ifdef CCFF_LOADER_READBACK_EN
         ST_VERIFY: begin
            shift_en_s = 1'b1;
            head_s     = ccff_tail;
            last_s     = (cnt_r == CNT_LAST);
            ready_s    = 1'b0;
         end
`endif
         default: begin
            shift_en_s = 1'b0;
            head_s     = 1'b0;
            ready_s    = 1'b0;
            last_s     = 1'b0;
         end
      endcase
   end

   // Main FSM: word holding register, bits-left and shifted-bit counters, done pulse
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_r     <= ST_IDLE;
         sreg_r      <= {DATA_W{1'b0}};
         bits_left_r <= BL_ZERO;
         cnt_r       <= CNT_ZERO;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r     <= ST_LOAD;
                  bits_left_r <= BL_ZERO;
                  cnt_r       <= CNT_ZERO;
               end
            end
            ST_LOAD: begin
               if (shift_en_s) begin
                  sreg_r      <= {sreg_r[DATA_W-2:0], 1'b0};
                  bits_left_r <= bits_left_r - BL_ONE;
                  cnt_r       <= cnt_r + CNT_ONE;
               end
               if (s_valid && ready_s) begin
                  sreg_r      <= s_data;
                  bits_left_r <= BL_FULL;
               end
               if (last_s) begin
                  // leftover bits of the final word are simply dropped here
                  bits_left_r <= BL_ZERO;
                  cnt_r       <= CNT_ZERO;
`ifdef CCFF_LOADER_READBACK_EN
                  state_r     <= ST_VERIFY;
`else
                  state_r     <= ST_FINISH;
                  done_r      <= 1'b1;
`endif
               end
            end
`ifdef CCFF_LOADER_READBACK_EN
            ST_VERIFY: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (last_s) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= ST_FINISH;
                  done_r  <= 1'b1;
               end
            end
`endif
            ST_FINISH: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef CCFF_LOADER_READBACK_EN
   logic [7:0] crc_load_s;
   logic [7:0] crc_read_s;
   logic       err_r;

   ccff_crc8 u_crc_load (
      .clk      (prog_clk),
      .rst_n    (prog_rst_n),
      .clear    (start_ok_s),
      .bit_en   ((state_r == ST_LOAD) && shift_en_s),
      .data_bit (head_s),
      .crc      (crc_load_s)
   );

   ccff_crc8 u_crc_read (
      .clk      (prog_clk),
      .rst_n    (prog_rst_n),
      .clear    (start_ok_s),
      .bit_en   (state_r == ST_VERIFY),
      .data_bit (ccff_tail),
      .crc      (crc_read_s)
   );

   // Readback verdict: taken in FINISH once both CRCs hold every bit, held until a new start
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         err_r <= 1'b0;
      end else if (start_ok_s) begin
         err_r <= 1'b0;
      end else if (state_r == ST_FINISH) begin
         err_r <= err_r | (crc_load_s != crc_read_s);
      end else begin
         err_r <= err_r;
      end
   end

   assign err = err_r;
`else
   logic unused_tail_s;
   assign unused_tail_s = ccff_tail ^ start_ok_s;
   assign err           = 1'b0;
`endif

   assign s_ready   = ready_s;
   assign ccff_head = head_s;
   assign shift_en  = shift_en_s;
   assign busy      = (state_r != ST_IDLE);
   assign done      = done_r;

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: expected head bits and completion records are queued
// by the stimulus and popped by a negedge monitor driving a behavioural chain model.
`timescale 1ns/1ps
module tb_ccff_loader;

   localparam int DATA_W    = 8;
   localparam int CHAIN_LEN = 36;
`ifdef CCFF_LOADER_READBACK_EN
   localparam int VSHIFTS = CHAIN_LEN;
`else
   localparam int VSHIFTS = 0;
`endif

   localparam logic [39:0] W1 = 40'hA53CF0965E;
   localparam logic [35:0] C1 = 36'hA53CF0965;
   localparam logic [39:0] W2 = 40'h0180FF00C3;
   localparam logic [35:0] C2 = 36'h0180FF00C;

   logic prog_clk   = 1'b0;
   logic prog_rst_n = 1'b0;
   logic start      = 1'b0;
   logic s_valid    = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic s_ready, ccff_head, ccff_tail, shift_en, busy, done, err;

   logic [CHAIN_LEN-1:0] chain    = '0;
   logic [CHAIN_LEN-1:0] flip_req = '0;

   typedef struct {
      int          total;
      int          span;
      bit          chk_chain;
      logic [35:0] chain;
      bit          err;
   } done_rec_t;

   done_rec_t done_q[$];
   logic      exp_bits[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0, shifts = 0, first_cyc = -1, last_cyc = -1;
   bit err_pend = 1'b0, err_exp = 1'b0, abort = 1'b0;

   ccff_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .ccff_head  (ccff_head),
      .ccff_tail  (ccff_tail),
      .shift_en   (shift_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: captures head only when shift_en; flip_req injects a one-off corruption
   assign ccff_tail = chain[CHAIN_LEN-1];
   always @(posedge prog_clk) begin
      if (shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head} ^ flip_req;
      else          chain <= chain ^ flip_req;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Monitor: pops expected head bits per load shift and a completion record per done pulse
   always @(negedge prog_clk) begin : mon
      done_rec_t rec;
      cyc++;
      if (err_pend) begin
         check("err_after_done", err, err_exp);
         err_pend = 1'b0;
      end
      if (!busy) begin
         shifts = 0; first_cyc = -1; last_cyc = -1;
      end
      if (shift_en) begin
         if (shifts < CHAIN_LEN) begin
            if (exp_bits.size() == 0) fail_now("unexpected_shift");
            else check("head_bit", ccff_head, exp_bits.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end else begin
            check("verify_recirc", ccff_head, ccff_tail);
            check("verify_ready", s_ready, 1'b0);
         end
         shifts++;
      end
      if (done) begin
         if (done_q.size() == 0) begin
            fail_now("unexpected_done");
         end else begin
            rec = done_q.pop_front();
            check("shift_total", shifts, rec.total);
            check("load_span", last_cyc - first_cyc + 1, rec.span);
            if (rec.chk_chain) check("chain_contents", chain, rec.chain);
            err_pend = 1'b1;
            err_exp  = rec.err;
         end
      end
   end

   task automatic expect_run(input logic [39:0] words, input logic [35:0] exp_chain,
                             input int span, input bit chk, input bit e);
      done_rec_t r;
      for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back(words[39-i]);
      r.total = CHAIN_LEN + VSHIFTS;
      r.span = span;
      r.chk_chain = chk;
      r.chain = exp_chain;
      r.err = e;
      done_q.push_back(r);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d);
      bit acc;
      bit ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 100 && !abort; i++) begin
         acc = s_ready;
         @(negedge prog_clk);
         if (acc) begin ok = 1'b1; break; end
      end
      if (!ok && !abort) fail_now("send_timeout");
   endtask

   task automatic stream(input logic [39:0] words, input int gap_idx, input int gap);
      for (int w = 0; w < 5; w++) begin
         if (abort) break;
         send_word(words[39-8*w -: 8]);
         if (w == gap_idx) begin
            s_valid = 1'b0;
            repeat (DATA_W - 1 + gap) @(negedge prog_clk);
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge prog_clk);
         if (done_q.size() == 0 && !err_pend) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now({name, "_done_timeout"});
      check({name, "_bits_left"}, exp_bits.size(), 0);
   endtask

   task automatic wait_shifts(input int n);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge prog_clk); #1;
         if (shifts >= n) begin hit = 1'b1; break; end
      end
      if (!hit) fail_now("shift_wait_timeout");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge prog_clk);
      check("reset_outputs", {s_ready, shift_en, ccff_head, busy, done, err}, 6'b000000);
      prog_rst_n = 1'b1;
      @(negedge prog_clk);

      // five words back-to-back, last nibble dropped
      expect_run(W1, C1, 36, 1'b1, 1'b0);
      do_start();
      stream(W1, -1, 0);
      wait_done("b2b");

      // three-cycle input stall after the second word
      expect_run(W2, C2, 39, 1'b1, 1'b0);
      do_start();
      stream(W2, 1, 3);
      wait_done("stall");

      // start pulsed again mid-load must be ignored
      expect_run(W1, C1, 36, 1'b1, 1'b0);
      do_start();
      fork
         stream(W1, -1, 0);
         begin
            repeat (12) @(negedge prog_clk);
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
         end
      join
      wait_done("restart_ignored");
      check("idle_after_run", busy, 1'b0);

      // asynchronous reset after 20 shifts, then a full reload
      expect_run(W2, C2, 36, 1'b1, 1'b0);
      do_start();
      fork
         stream(W2, -1, 0);
         begin
            wait_shifts(20);
            abort = 1'b1;
            prog_rst_n = 1'b0;
            #1;
            check("async_reset_outputs", {s_ready, shift_en, ccff_head, busy, done, err}, 6'b000000);
            exp_bits.delete();
            done_q.delete();
         end
      join
      repeat (2) @(negedge prog_clk);
      prog_rst_n = 1'b1;
      abort = 1'b0;
      @(negedge prog_clk);
      check("no_done_after_abort", done, 1'b0);
      expect_run(W1, C1, 36, 1'b1, 1'b0);
      do_start();
      stream(W1, -1, 0);
      wait_done("reload");

`ifdef CCFF_LOADER_READBACK_EN
      // faithful readback keeps the chain and reports no error
      expect_run(W2, C2, 36, 1'b1, 1'b0);
      do_start();
      stream(W2, -1, 0);
      wait_done("readback_ok");

      // one corrupted chain bit must raise err after done
      expect_run(W1, C1, 36, 1'b0, 1'b1);
      do_start();
      fork
         stream(W1, -1, 0);
         begin
            wait_shifts(30);
            flip_req = 36'h000000001;
            @(negedge prog_clk);
            flip_req = 36'h000000000;
         end
      join
      wait_done("readback_bad");
      check("err_sticky", err, 1'b1);
      expect_run(W2, C2, 36, 1'b1, 1'b0);
      do_start();
      check("err_cleared_by_start", err, 1'b0);
      stream(W2, -1, 0);
      wait_done("readback_clean");
`endif

      repeat (3) @(negedge prog_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
